// File: rtl/g15_accessory_pkg.sv
// Shared word geometry and input-FSM state encoding for the PL19/PL20
// accessory responder.
package g15_accessory_pkg;

   localparam int WORD_BITS = 29;
   localparam int CNT_W     = 5;

   // Bit index of the last bit in a word, sized for the bit counters.
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WORD_BITS - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(WORD_BITS);

   typedef enum logic [1:0] {
      I_IDLE,
      I_WAIT,
      I_SEND
   } in_state_t;

endpackage

// File: rtl/pl_strobe_edge.sv
// Rising-edge detector for CPU strobes: one register per strobe, and the
// rise is the live level high while the registered copy is still low.
module pl_strobe_edge #(
   parameter int W = 1
) (
   input  logic         CLOCK,
   input  logic         rst,
   input  logic [W-1:0] strobe,
   output logic [W-1:0] rise
);

   logic [W-1:0] strobe_q;
   logic [W-1:0] strobe_d;

   always_comb begin
      strobe_d = strobe;
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every flop samples the pre-edge values regardless of block ordering.
   always_ff @(posedge CLOCK or posedge rst) begin
      if (rst) begin
         strobe_q <= '0;
      end else begin
         strobe_q <= strobe_d;
      end
   end

   assign rise = strobe & ~strobe_q;

endmodule

// File: rtl/pl_accessory_port.sv
// Accessory-side responder for the CPU PL19 (serial input) and PL20 (serial
// output) connectors, presenting word-wide valid/ready ports to the accessory.
module pl_accessory_port
   import g15_accessory_pkg::*;
(
   input  logic                 CLOCK,
   input  logic                 rst,
   input  logic                 PL19_START_INPUT,
   input  logic                 PL19_STOP_INPUT,
   input  logic                 PL19_SHIFT_CMD,
   input  logic                 PL19_SHIFT_CMD_M20,
   input  logic                 PL19_WRITE_PULSE,
   input  logic                 PL20_OUTPUT,
   input  logic                 PL20_OUTPUT_SHIFT,
   output logic                 PL19_INPUT,
   output logic                 PL19_READY_IN,
   output logic                 PL20_READY_OUT,
   input  logic [WORD_BITS-1:0] in_word,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [WORD_BITS-1:0] out_word,
   output logic [CNT_W-1:0]     out_count,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 underrun,
   output logic                 overrun,
   input  logic                 err_clr
);

   logic start_rise;
   logic stop_rise;
   logic shift_rise;
   logic oshift_rise;
   logic wp_rise;

   pl_strobe_edge #(.W(1)) u_start_edge (
      .CLOCK  (CLOCK),
      .rst    (rst),
      .strobe (PL19_START_INPUT),
      .rise   (start_rise)
   );

   pl_strobe_edge #(.W(1)) u_stop_edge (
      .CLOCK  (CLOCK),
      .rst    (rst),
      .strobe (PL19_STOP_INPUT),
      .rise   (stop_rise)
   );

   // Both input strobes are merged before edge detection.
   pl_strobe_edge #(.W(1)) u_shift_edge (
      .CLOCK  (CLOCK),
      .rst    (rst),
      .strobe (PL19_SHIFT_CMD | PL19_SHIFT_CMD_M20),
      .rise   (shift_rise)
   );

   pl_strobe_edge #(.W(2)) u_out_edge (
      .CLOCK  (CLOCK),
      .rst    (rst),
      .strobe ({PL19_WRITE_PULSE, PL20_OUTPUT_SHIFT}),
      .rise   ({wp_rise, oshift_rise})
   );

   // ---------------- PL19 input path ----------------
   in_state_t                state_q,     state_d;
   logic [WORD_BITS-2:0]     shreg_q,     shreg_d;
   logic [CNT_W-1:0]         in_cnt_q,    in_cnt_d;
   logic                     pl19_input_q, pl19_input_d;
   logic                     pl19_ready_q, pl19_ready_d;
   logic                     underrun_q,  underrun_d;
   logic                     load;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the case statement can infer a latch.
      state_d      = state_q;
      shreg_d      = shreg_q;
      in_cnt_d     = in_cnt_q;
      pl19_input_d = pl19_input_q;
      pl19_ready_d = pl19_ready_q;
      underrun_d   = underrun_q;
      in_ready     = 1'b0;
      load         = 1'b0;

      case (state_q)
         I_IDLE: begin
            if (start_rise) begin
               state_d = I_WAIT;
            end
         end
         I_WAIT: begin
            in_ready = 1'b1;
            load     = in_valid;
         end
         I_SEND: begin
            if (shift_rise) begin
               if (in_cnt_q == LAST_BIT) begin
                  // Word exhausted: chain the next word without a gap if offered.
                  in_ready = 1'b1;
                  if (in_valid) begin
                     load = 1'b1;
                  end else begin
                     pl19_ready_d = 1'b0;
                     pl19_input_d = 1'b0;
                     state_d      = I_WAIT;
                  end
               end else begin
                  pl19_input_d = shreg_q[0];
                  shreg_d      = shreg_q >> 1;
                  in_cnt_d     = in_cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = I_IDLE;
         end
      endcase

      if (load) begin
         pl19_input_d = in_word[0];
         shreg_d      = in_word[WORD_BITS-1:1];
         in_cnt_d     = '0;
         pl19_ready_d = 1'b1;
         state_d      = I_SEND;
      end

      // STOP overrides everything, including a START or transfer in the same cycle.
      if (stop_rise) begin
         in_ready     = 1'b0;
         state_d      = I_IDLE;
         shreg_d      = '0;
         in_cnt_d     = '0;
         pl19_input_d = 1'b0;
         pl19_ready_d = 1'b0;
      end

      if (err_clr) begin
         underrun_d = 1'b0;
      end
      if (shift_rise && (state_q != I_SEND)) begin
         underrun_d = 1'b1;
      end
   end

   always_ff @(posedge CLOCK or posedge rst) begin
      if (rst) begin
         state_q      <= I_IDLE;
         shreg_q      <= '0;
         in_cnt_q     <= '0;
         pl19_input_q <= 1'b0;
         pl19_ready_q <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         in_cnt_q     <= in_cnt_d;
         pl19_input_q <= pl19_input_d;
         pl19_ready_q <= pl19_ready_d;
         underrun_q   <= underrun_d;
      end
   end

   // ---------------- PL20 output path ----------------
   logic [WORD_BITS-1:0] asm_q,       asm_d;
   logic [CNT_W-1:0]     out_cnt_q,   out_cnt_d;
   logic [WORD_BITS-1:0] out_word_q,  out_word_d;
   logic [CNT_W-1:0]     out_count_q, out_count_d;
   logic                 out_valid_q, out_valid_d;
   logic                 overrun_q,   overrun_d;
   logic [WORD_BITS-1:0] asm_eff;
   logic [CNT_W-1:0]     cnt_eff;

   always_comb begin
      out_word_d  = out_word_q;
      out_count_d = out_count_q;
      out_valid_d = out_valid_q & ~out_ready;
      overrun_d   = overrun_q;
      asm_eff     = asm_q;
      cnt_eff     = out_cnt_q;

      if (err_clr) begin
         overrun_d = 1'b0;
      end

      // A bit landing together with WRITE_PULSE is stored before the commit.
      if (oshift_rise) begin
         if (out_valid_q) begin
            overrun_d = 1'b1;
         end else begin
            asm_eff[out_cnt_q] = PL20_OUTPUT;
            cnt_eff            = out_cnt_q + 1'b1;
         end
      end

      asm_d     = asm_eff;
      out_cnt_d = cnt_eff;

      if (!out_valid_q &&
          ((cnt_eff == FULL_CNT) || (wp_rise && (cnt_eff != '0)))) begin
         out_word_d  = asm_eff;
         out_count_d = cnt_eff;
         out_valid_d = 1'b1;
         asm_d       = '0;
         out_cnt_d   = '0;
      end
   end

   always_ff @(posedge CLOCK or posedge rst) begin
      if (rst) begin
         asm_q       <= '0;
         out_cnt_q   <= '0;
         out_word_q  <= '0;
         out_count_q <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         asm_q       <= asm_d;
         out_cnt_q   <= out_cnt_d;
         out_word_q  <= out_word_d;
         out_count_q <= out_count_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign PL19_INPUT     = pl19_input_q;
   assign PL19_READY_IN  = pl19_ready_q;
   assign PL20_READY_OUT = ~out_valid_q;
   assign out_word       = out_word_q;
   assign out_count      = out_count_q;
   assign out_valid      = out_valid_q;
   assign underrun       = underrun_q;
   assign overrun        = overrun_q;

endmodule

// File: tb/tb_pl_accessory_port.sv
// Scoreboard bench for pl_accessory_port: stimulus pushes expected PL19 bits
// and PL20 words; a negedge monitor pops and compares as the DUT presents them.
module tb_pl_accessory_port;

   logic        CLOCK = 1'b0;
   logic        rst;
   logic        PL19_START_INPUT, PL19_STOP_INPUT, PL19_SHIFT_CMD, PL19_SHIFT_CMD_M20;
   logic        PL19_WRITE_PULSE, PL20_OUTPUT, PL20_OUTPUT_SHIFT;
   logic        PL19_INPUT, PL19_READY_IN, PL20_READY_OUT;
   logic [28:0] in_word;
   logic        in_valid, in_ready;
   logic [28:0] out_word;
   logic [4:0]  out_count;
   logic        out_valid, out_ready;
   logic        underrun, overrun, err_clr;

   typedef struct {
      logic [28:0] w;
      logic [4:0]  c;
   } out_exp_t;

   logic     exp_bits[$];
   out_exp_t exp_out[$];
   int       checks = 0;
   int       errors = 0;

   pl_accessory_port dut (
      .CLOCK              (CLOCK),
      .rst                (rst),
      .PL19_START_INPUT   (PL19_START_INPUT),
      .PL19_STOP_INPUT    (PL19_STOP_INPUT),
      .PL19_SHIFT_CMD     (PL19_SHIFT_CMD),
      .PL19_SHIFT_CMD_M20 (PL19_SHIFT_CMD_M20),
      .PL19_WRITE_PULSE   (PL19_WRITE_PULSE),
      .PL20_OUTPUT        (PL20_OUTPUT),
      .PL20_OUTPUT_SHIFT  (PL20_OUTPUT_SHIFT),
      .PL19_INPUT         (PL19_INPUT),
      .PL19_READY_IN      (PL19_READY_IN),
      .PL20_READY_OUT     (PL20_READY_OUT),
      .in_word            (in_word),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .out_word           (out_word),
      .out_count          (out_count),
      .out_valid          (out_valid),
      .out_ready          (out_ready),
      .underrun           (underrun),
      .overrun            (overrun),
      .err_clr            (err_clr)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic report_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s (no expected event)", name);
   endtask

   // ---------------- monitor ----------------
   logic shift_prev = 1'b0;
   logic ready_prev = 1'b0;
   logic valid_prev = 1'b0;

   always @(negedge CLOCK) begin : monitor
      logic     shift_now;
      out_exp_t e;
      shift_now = PL19_SHIFT_CMD | PL19_SHIFT_CMD_M20;
      if (!rst) begin
         // A new PL19 bit is visible when READY_IN rises or after a shift pulse ends.
         if (PL19_READY_IN && (!ready_prev || (shift_prev && !shift_now))) begin
            if (exp_bits.size() == 0) report_fail("pl19_bit_unexpected");
            else check("pl19_bit", PL19_INPUT, exp_bits.pop_front());
         end
         if (out_valid && !valid_prev) begin
            if (exp_out.size() == 0) begin
               report_fail("out_word_unexpected");
            end else begin
               e = exp_out.pop_front();
               check("out_word", out_word, e.w);
               check("out_count", out_count, e.c);
               check("ready_out_low_at_commit", PL20_READY_OUT, 0);
            end
         end
      end
      shift_prev = shift_now;
      ready_prev = PL19_READY_IN;
      valid_prev = out_valid;
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge CLOCK);
         #1;
      end
   endtask

   task automatic pulse_shift(input bit alt);
      if (alt) PL19_SHIFT_CMD_M20 = 1'b1;
      else     PL19_SHIFT_CMD     = 1'b1;
      step(2);
      PL19_SHIFT_CMD     = 1'b0;
      PL19_SHIFT_CMD_M20 = 1'b0;
      step(2);
   endtask

   task automatic pulse_start();
      PL19_START_INPUT = 1'b1;
      step(2);
      PL19_START_INPUT = 1'b0;
      step(2);
   endtask

   task automatic pulse_stop();
      PL19_STOP_INPUT = 1'b1;
      step(2);
      PL19_STOP_INPUT = 1'b0;
      step(2);
   endtask

   task automatic pulse_wp();
      PL19_WRITE_PULSE = 1'b1;
      step(2);
      PL19_WRITE_PULSE = 1'b0;
      step(2);
   endtask

   task automatic out_shift(input logic b);
      PL20_OUTPUT       = b;
      PL20_OUTPUT_SHIFT = 1'b1;
      step(2);
      PL20_OUTPUT_SHIFT = 1'b0;
      step(2);
   endtask

   task automatic push_bits(input logic [28:0] w);
      for (int i = 0; i < 29; i++) exp_bits.push_back(w[i]);
   endtask

   task automatic send_word(input logic [28:0] w);
      in_word  = w;
      in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (in_ready) begin
            push_bits(w);
            step(1);
            in_valid = 1'b0;
            return;
         end
         step(1);
      end
      in_valid = 1'b0;
      report_fail("send_word_timeout");
   endtask

   task automatic handshake_out();
      out_ready = 1'b1;
      step(1);
      out_ready = 1'b0;
      step(1);
   endtask

   task automatic push_out(input logic [28:0] w, input logic [4:0] c);
      out_exp_t e;
      e.w = w;
      e.c = c;
      exp_out.push_back(e);
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog_timeout");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   initial begin : stimulus
      logic [28:0] w;
      rst = 1'b1;
      {PL19_START_INPUT, PL19_STOP_INPUT, PL19_SHIFT_CMD, PL19_SHIFT_CMD_M20} = '0;
      {PL19_WRITE_PULSE, PL20_OUTPUT, PL20_OUTPUT_SHIFT} = '0;
      in_word = '0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
      step(3);

      // Reset values.
      check("rst_pl19_input", PL19_INPUT, 0);
      check("rst_ready_in", PL19_READY_IN, 0);
      check("rst_ready_out", PL20_READY_OUT, 1);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_word", out_word, 0);
      check("rst_out_count", out_count, 0);
      check("rst_underrun", underrun, 0);
      check("rst_overrun", overrun, 0);
      rst = 1'b0;
      step(2);
      check("idle_in_ready", in_ready, 0);

      // Single input word, alternating pattern, no follow-on word.
      pulse_start();
      check("wait_in_ready", in_ready, 1);
      send_word(29'h1555_5555);
      check("loaded_ready_in", PL19_READY_IN, 1);
      for (int i = 0; i < 29; i++) pulse_shift(i[0]);
      check("word_end_ready_in", PL19_READY_IN, 0);
      check("word_end_in_ready", in_ready, 1);

      // Underrun: shift while waiting for a word.
      pulse_shift(1'b1);
      check("underrun_set", underrun, 1);
      check("underrun_pl19_input", PL19_INPUT, 0);
      check("underrun_ready_in", PL19_READY_IN, 0);
      step(3);
      check("underrun_sticky", underrun, 1);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      check("underrun_cleared", underrun, 0);

      // Back-to-back words, then STOP partway through the second.
      send_word(29'h0000_0001);
      in_word  = 29'h1000_0000;
      in_valid = 1'b1;
      for (int i = 0; i < 28; i++) pulse_shift(1'b0);
      push_bits(29'h1000_0000);
      pulse_shift(1'b0);
      in_valid = 1'b0;
      check("b2b_no_gap_ready_in", PL19_READY_IN, 1);
      for (int i = 0; i < 28; i++) pulse_shift(1'b0);
      check("stream_bit57", PL19_INPUT, 1);
      pulse_stop();
      exp_bits.delete();
      check("stop_pl19_input", PL19_INPUT, 0);
      check("stop_ready_in", PL19_READY_IN, 0);
      check("stop_idle_in_ready", in_ready, 0);

      // Asynchronous reset in the middle of a word.
      pulse_start();
      send_word(29'h0123_4567);
      for (int i = 0; i < 10; i++) pulse_shift(1'b0);
      #2 rst = 1'b1;
      #1;
      check("midrst_ready_in", PL19_READY_IN, 0);
      check("midrst_pl19_input", PL19_INPUT, 0);
      check("midrst_idle_in_ready", in_ready, 0);
      check("midrst_ready_out", PL20_READY_OUT, 1);
      exp_bits.delete();
      step(2);
      rst = 1'b0;
      step(2);

      // Full output word, then a 30th shift before the handshake.
      w = 29'h0ABC_DEF1;
      push_out(w, 5'd29);
      for (int i = 0; i < 29; i++) out_shift(w[i]);
      check("full_out_valid", out_valid, 1);
      check("full_ready_out", PL20_READY_OUT, 0);
      out_shift(1'b1);
      check("overrun_set", overrun, 1);
      check("overrun_word_kept", out_word, 29'h0ABC_DEF1);
      handshake_out();
      check("handshake_clears_valid", out_valid, 0);
      check("handshake_ready_out", PL20_READY_OUT, 1);
      err_clr = 1'b1;
      step(1);
      err_clr = 1'b0;
      check("overrun_cleared", overrun, 0);

      // Short word terminated by WRITE_PULSE.
      push_out(29'h1F, 5'd5);
      for (int i = 0; i < 5; i++) out_shift(1'b1);
      pulse_wp();
      check("short_out_valid", out_valid, 1);
      handshake_out();

      // Shift and WRITE_PULSE together: bits 1,0,0,1,0 then 1 -> 6'b101001.
      push_out(29'h29, 5'd6);
      out_shift(1'b1); out_shift(1'b0); out_shift(1'b0);
      out_shift(1'b1); out_shift(1'b0);
      PL20_OUTPUT       = 1'b1;
      PL20_OUTPUT_SHIFT = 1'b1;
      PL19_WRITE_PULSE  = 1'b1;
      step(2);
      PL20_OUTPUT_SHIFT = 1'b0;
      PL19_WRITE_PULSE  = 1'b0;
      step(2);
      check("combo_out_count", out_count, 6);
      handshake_out();

      // WRITE_PULSE with nothing accumulated does nothing.
      pulse_wp();
      step(2);
      check("empty_wp_no_valid", out_valid, 0);

      step(4);
      check("pl19_queue_drained", exp_bits.size(), 0);
      check("out_queue_drained", exp_out.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
